// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register for the 5-stage MIPS core. It captures the
//   Control decoder outputs, register file operands and instruction fields
//   from ID and presents them to EX one cycle later. A taken branch/jump
//   (flush) turns the captured instruction into a bubble. A load in EX whose
//   destination is read by the instruction in ID raises a load-use stall for
//   the PC and IF/ID, and inserts exactly one bubble. Load-use bubbles are
//   counted in a saturating counter for performance reporting.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   id_RegWrite .. id_ALUSrc, id_ALUOP   Control outputs for the ID instruction
//   id_pc4, id_rd1, id_rd2, id_imm       PC+4, register operands, sign-ext imm
//   id_rs, id_rt, id_rd, id_funct        instruction fields
//   flush                kill the ID instruction (bubble into EX)
//   hold                 downstream stall, freeze every register here
//   ex_*                 registered copies of the id_* inputs
//   ex_valid             EX holds a real instruction rather than a bubble
//   stall                load-use stall request to PC and IF/ID
//   bubble_cnt           saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_RegWrite,
  input  logic              id_MemtoReg,
  input  logic              id_MemWrite,
  input  logic              id_MemRead,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic [1:0]        id_ALUOP,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_RegWrite,
  output logic              ex_MemtoReg,
  output logic              ex_MemWrite,
  output logic              ex_MemRead,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic [1:0]        ex_ALUOP,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [5:0]        ex_funct,
  output logic              ex_valid,
  output logic              stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic hz;

  // Load-use hazard: a real load in EX writes a register (never $0) that the
  // ID instruction reads. Uses only registered EX state plus ID fields.
  always_comb begin
    hz    = ex_valid & ex_MemRead & (ex_rt != '0) &
            ((ex_rt == id_rs) | (ex_rt == id_rt));
    stall = hz & ~flush;
  end

  // Data fields load on every non-hold edge, bubbles included; their
  // contents are meaningless in a bubble because the controls are zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_pc4   <= '0;
      ex_rd1   <= '0;
      ex_rd2   <= '0;
      ex_imm   <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      ex_funct <= '0;
    end else if (flush || !hold) begin
      ex_pc4   <= id_pc4;
      ex_rd1   <= id_rd1;
      ex_rd2   <= id_rd2;
      ex_imm   <= id_imm;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      ex_funct <= id_funct;
    end
  end

  // Control bits: flush beats hold beats hazard. Both flush and hazard load
  // a bubble; only the hazard bubble is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOP    <= 2'b00;
      ex_valid    <= 1'b0;
      bubble_cnt  <= '0;
    end else if (flush || (!hold && hz)) begin
      ex_RegWrite <= 1'b0;
      ex_MemtoReg <= 1'b0;
      ex_MemWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
      ex_RegDst   <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_ALUOP    <= 2'b00;
      ex_valid    <= 1'b0;
      if (!flush && (bubble_cnt != '1)) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end else if (!hold) begin
      ex_RegWrite <= id_RegWrite;
      ex_MemtoReg <= id_MemtoReg;
      ex_MemWrite <= id_MemWrite;
      ex_MemRead  <= id_MemRead;
      ex_RegDst   <= id_RegDst;
      ex_ALUSrc   <= id_ALUSrc;
      ex_ALUOP    <= id_ALUOP;
      ex_valid    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
//   Directed scoreboard bench for id_ex_stage. Each row drives one ID
//   instruction and carries the hand-computed EX state expected while that
//   row is on the inputs (the result of the previous edge) plus the expected
//   stall. A second instance with CNT_W=2 shares the inputs to exercise
//   counter saturation.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  localparam logic [5:0] R_T = 6'b100010;  // RegWrite, RegDst
  localparam logic [5:0] LW  = 6'b110101;  // RegWrite, MemtoReg, MemRead, ALUSrc

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead, id_RegDst, id_ALUSrc;
  logic [1:0]  id_ALUOP;
  logic [31:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_funct;
  logic        flush, hold;

  logic        ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_MemRead, ex_RegDst, ex_ALUSrc;
  logic [1:0]  ex_ALUOP;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [5:0]  ex_funct;
  logic        ex_valid, stall;
  logic [15:0] bubble_cnt;

  logic        s_RegWrite, s_MemtoReg, s_MemWrite, s_MemRead, s_RegDst, s_ALUSrc;
  logic [1:0]  s_ALUOP;
  logic [31:0] s_pc4, s_rd1, s_rd2, s_imm;
  logic [4:0]  s_rs, s_rt, s_rd;
  logic [5:0]  s_funct;
  logic        s_valid, s_stall;
  logic [1:0]  s_cnt;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite),
    .id_MemRead(id_MemRead), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
    .id_ALUOP(id_ALUOP), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .hold(hold),
    .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_MemWrite(ex_MemWrite),
    .ex_MemRead(ex_MemRead), .ex_RegDst(ex_RegDst), .ex_ALUSrc(ex_ALUSrc),
    .ex_ALUOP(ex_ALUOP), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .ex_valid(ex_valid), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite),
    .id_MemRead(id_MemRead), .id_RegDst(id_RegDst), .id_ALUSrc(id_ALUSrc),
    .id_ALUOP(id_ALUOP), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .hold(hold),
    .ex_RegWrite(s_RegWrite), .ex_MemtoReg(s_MemtoReg), .ex_MemWrite(s_MemWrite),
    .ex_MemRead(s_MemRead), .ex_RegDst(s_RegDst), .ex_ALUSrc(s_ALUSrc),
    .ex_ALUOP(s_ALUOP), .ex_pc4(s_pc4), .ex_rd1(s_rd1), .ex_rd2(s_rd2),
    .ex_imm(s_imm), .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_funct(s_funct),
    .ex_valid(s_valid), .stall(s_stall), .bubble_cnt(s_cnt)
  );

  typedef struct {
    logic [5:0]  ctrl;
    logic [1:0]  alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rd1;
    logic        fl;
    logic        ho;
    logic        e_rst;
    logic [5:0]  e_ctrl;
    logic [1:0]  e_alu;
    logic        e_valid;
    logic [31:0] e_rd1;
    logic [4:0]  e_rt;
    logic [4:0]  e_rs;
    logic        e_stall;
    logic [15:0] e_cnt;
    logic [1:0]  e_cnt2;
    int          idx;
  } row_t;

  row_t rows[22];
  row_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic row_t mk(logic [5:0] ctrl, logic [1:0] alu, logic [4:0] rs, logic [4:0] rt,
                              logic [31:0] rd1, logic fl, logic ho, logic e_rst,
                              logic [5:0] e_ctrl, logic [1:0] e_alu, logic e_valid,
                              logic [31:0] e_rd1, logic [4:0] e_rt, logic [4:0] e_rs,
                              logic e_stall, logic [15:0] e_cnt, logic [1:0] e_cnt2);
    row_t r;
    r.ctrl = ctrl; r.alu = alu; r.rs = rs; r.rt = rt; r.rd1 = rd1; r.fl = fl; r.ho = ho;
    r.e_rst = e_rst; r.e_ctrl = e_ctrl; r.e_alu = e_alu; r.e_valid = e_valid;
    r.e_rd1 = e_rd1; r.e_rt = e_rt; r.e_rs = e_rs; r.e_stall = e_stall;
    r.e_cnt = e_cnt; r.e_cnt2 = e_cnt2; r.idx = 0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s row=%0d got=%h want=%h", name, idx, act, exp);
    end
  endtask

  // Drive one ID instruction; the non-checked-by-row fields are simple
  // functions of rd1/rt so the monitor can predict them.
  task automatic applyStimulus(input row_t r);
    {id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead, id_RegDst, id_ALUSrc} = r.ctrl;
    id_ALUOP = r.alu;
    id_rs    = r.rs;
    id_rt    = r.rt;
    id_rd    = r.rt + 5'd1;
    id_rd1   = r.rd1;
    id_rd2   = ~r.rd1;
    id_imm   = r.rd1 ^ 32'h0F0F0F0F;
    id_pc4   = r.rd1 + 32'd4;
    id_funct = r.rd1[5:0];
    flush    = r.fl;
    hold     = r.ho;
    exp_q.push_back(r);
  endtask

  // Monitor: every cycle, after the current row has settled, compare the EX
  // state and stall against the oldest queued expectation.
  initial begin : monitor
    row_t r;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        r = exp_q.pop_front();
        checkOutput("ctrl", r.idx,
          {26'd0, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_MemRead, ex_RegDst, ex_ALUSrc},
          {26'd0, r.e_ctrl});
        checkOutput("aluop", r.idx, {30'd0, ex_ALUOP}, {30'd0, r.e_alu});
        checkOutput("valid", r.idx, {31'd0, ex_valid}, {31'd0, r.e_valid});
        checkOutput("rd1", r.idx, ex_rd1, r.e_rd1);
        checkOutput("rt", r.idx, {27'd0, ex_rt}, {27'd0, r.e_rt});
        checkOutput("rs", r.idx, {27'd0, ex_rs}, {27'd0, r.e_rs});
        checkOutput("stall", r.idx, {31'd0, stall}, {31'd0, r.e_stall});
        checkOutput("cnt", r.idx, {16'd0, bubble_cnt}, {16'd0, r.e_cnt});
        checkOutput("cnt_sat", r.idx, {30'd0, s_cnt}, {30'd0, r.e_cnt2});
        if (r.e_rst) begin
          checkOutput("pc4", r.idx, ex_pc4, 32'd0);
          checkOutput("rd2", r.idx, ex_rd2, 32'd0);
          checkOutput("imm", r.idx, ex_imm, 32'd0);
          checkOutput("rd", r.idx, {27'd0, ex_rd}, 32'd0);
          checkOutput("funct", r.idx, {26'd0, ex_funct}, 32'd0);
        end else begin
          checkOutput("pc4", r.idx, ex_pc4, r.e_rd1 + 32'd4);
          checkOutput("rd2", r.idx, ex_rd2, ~r.e_rd1);
          checkOutput("imm", r.idx, ex_imm, r.e_rd1 ^ 32'h0F0F0F0F);
          checkOutput("rd", r.idx, {27'd0, ex_rd}, {27'd0, 5'(r.e_rt + 5'd1)});
          checkOutput("funct", r.idx, {26'd0, ex_funct}, {26'd0, r.e_rd1[5:0]});
        end
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog timeout");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : stimulus
    //          in: ctrl  alu   rs  rt  rd1         fl ho | exp: rst ctrl alu   v  rd1         rt  rs  st cnt cnt2
    rows[0]  = mk(R_T, 2'b10, 1, 2, 32'h1234, 0, 0, 1, 6'd0, 2'b00, 0, 32'h0,    0, 0, 0, 0, 0);
    rows[1]  = mk(LW,  2'b00, 4, 8, 32'h100,  0, 0, 0, R_T,  2'b10, 1, 32'h1234, 2, 1, 0, 0, 0);
    rows[2]  = mk(R_T, 2'b10, 8, 9, 32'h55,   0, 0, 0, LW,   2'b00, 1, 32'h100,  8, 4, 1, 0, 0);
    rows[3]  = mk(R_T, 2'b10, 8, 9, 32'h55,   0, 0, 0, 6'd0, 2'b00, 0, 32'h55,   9, 8, 0, 1, 1);
    rows[4]  = mk(LW,  2'b00, 5, 0, 32'h200,  0, 0, 0, R_T,  2'b10, 1, 32'h55,   9, 8, 0, 1, 1);
    rows[5]  = mk(R_T, 2'b10, 0, 0, 32'h66,   0, 0, 0, LW,   2'b00, 1, 32'h200,  0, 5, 0, 1, 1);
    rows[6]  = mk(LW,  2'b00, 1, 7, 32'h300,  0, 0, 0, R_T,  2'b10, 1, 32'h66,   0, 0, 0, 1, 1);
    rows[7]  = mk(R_T, 2'b10, 3, 7, 32'h77,   1, 0, 0, LW,   2'b00, 1, 32'h300,  7, 1, 0, 1, 1);
    rows[8]  = mk(LW,  2'b00, 2, 6, 32'h400,  0, 0, 0, 6'd0, 2'b00, 0, 32'h77,   7, 3, 0, 1, 1);
    rows[9]  = mk(R_T, 2'b10, 6, 1, 32'h88,   0, 1, 0, LW,   2'b00, 1, 32'h400,  6, 2, 1, 1, 1);
    rows[10] = mk(R_T, 2'b10, 6, 1, 32'h88,   0, 1, 0, LW,   2'b00, 1, 32'h400,  6, 2, 1, 1, 1);
    rows[11] = mk(R_T, 2'b10, 6, 1, 32'h88,   0, 1, 0, LW,   2'b00, 1, 32'h400,  6, 2, 1, 1, 1);
    rows[12] = mk(R_T, 2'b10, 6, 1, 32'h88,   0, 0, 0, LW,   2'b00, 1, 32'h400,  6, 2, 1, 1, 1);
    rows[13] = mk(R_T, 2'b10, 6, 1, 32'h88,   0, 0, 0, 6'd0, 2'b00, 0, 32'h88,   1, 6, 0, 2, 2);
    rows[14] = mk(LW,  2'b00, 0, 5, 32'h500,  0, 0, 0, R_T,  2'b10, 1, 32'h88,   1, 6, 0, 2, 2);
    rows[15] = mk(R_T, 2'b10, 5, 0, 32'h99,   0, 0, 0, LW,   2'b00, 1, 32'h500,  5, 0, 1, 2, 2);
    rows[16] = mk(LW,  2'b00, 5, 5, 32'h600,  0, 0, 0, 6'd0, 2'b00, 0, 32'h99,   0, 5, 0, 3, 3);
    rows[17] = mk(R_T, 2'b10, 1, 5, 32'hAA,   0, 0, 0, LW,   2'b00, 1, 32'h600,  5, 5, 1, 3, 3);
    rows[18] = mk(LW,  2'b00, 5, 4, 32'h700,  0, 0, 0, 6'd0, 2'b00, 0, 32'hAA,   5, 1, 0, 4, 3);
    rows[19] = mk(R_T, 2'b10, 4, 4, 32'hBB,   0, 0, 0, LW,   2'b00, 1, 32'h700,  4, 5, 1, 4, 3);
    rows[20] = mk(6'd0,2'b00, 0, 0, 32'h0,    0, 0, 0, 6'd0, 2'b00, 0, 32'hBB,   4, 4, 0, 5, 3);
    rows[21] = mk(R_T, 2'b10, 1, 2, 32'hCC,   0, 0, 0, 6'd0, 2'b00, 1, 32'h0,    0, 0, 0, 5, 3);

    {id_RegWrite, id_MemtoReg, id_MemWrite, id_MemRead, id_RegDst, id_ALUSrc} = 6'd0;
    id_ALUOP = 2'b00; id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_funct = '0; flush = 1'b0; hold = 1'b0;

    #1;
    checkOutput("reset_valid", -1, {31'd0, ex_valid}, 32'd0);
    checkOutput("reset_cnt", -1, {16'd0, bubble_cnt}, 32'd0);
    checkOutput("reset_stall", -1, {31'd0, stall}, 32'd0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      rows[i].idx = i;
      applyStimulus(rows[i]);
    end

    begin : drain
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      if (exp_q.size() > 0) begin
        bad++;
        $display("[TB] FAIL drain left=%0d", exp_q.size());
      end
    end

    // Last row (R-type) is now in EX; assert reset between edges.
    @(negedge clk);
    #3;
    checkOutput("pre_rst_regwrite", 99, {31'd0, ex_RegWrite}, 32'd1);
    checkOutput("pre_rst_rd1", 99, ex_rd1, 32'hCC);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_ctrl", 99,
      {26'd0, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_MemRead, ex_RegDst, ex_ALUSrc}, 32'd0);
    checkOutput("async_rst_alu", 99, {30'd0, ex_ALUOP}, 32'd0);
    checkOutput("async_rst_valid", 99, {31'd0, ex_valid}, 32'd0);
    checkOutput("async_rst_rd1", 99, ex_rd1, 32'd0);
    checkOutput("async_rst_rt", 99, {27'd0, ex_rt}, 32'd0);
    checkOutput("async_rst_cnt", 99, {16'd0, bubble_cnt}, 32'd0);
    checkOutput("async_rst_cnt_sat", 99, {30'd0, s_cnt}, 32'd0);
    checkOutput("async_rst_stall", 99, {31'd0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
